// File: rtl/pad6_seq.sv
// Six-button pad read sequencer for one controller port.
// Counts TH rising edges to select the button group driven onto the port data bits.
module pad6_seq #(
    parameter int TIMEOUT = 11520,
    parameter int TW      = 14
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE,
    input  logic       J3BUT,
    input  logic       TH,
    input  logic       UP,
    input  logic       DOWN,
    input  logic       LEFT,
    input  logic       RIGHT,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       START,
    input  logic       MODE,
    input  logic       X,
    input  logic       Y,
    input  logic       Z,
    output logic [6:0] DATA,
    output logic [1:0] PHASE
);

    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    logic          th_q;
    logic          rise;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic [1:0]    phase_d;
    logic [5:0]    bits_d;

    always_comb begin
        rise    = TH & ~th_q;
        phase_d = PHASE;
        timer_d = timer;
        if (J3BUT) begin
            phase_d = 2'd0;
            timer_d = '0;
        end else if (rise) begin
            phase_d = PHASE + 2'd1;
            timer_d = '0;
        end else if (timer == TMAX) begin
            phase_d = 2'd0;
            timer_d = '0;
        end else if (PHASE != 2'd0) begin
            timer_d = timer + TW'(1);
        end
    end

    // Row select uses the phase being entered on this CE, not the old one.
    always_comb begin
        bits_d = 6'h3F;
        unique case ({TH, phase_d})
            3'b100, 3'b101, 3'b110:
                bits_d = {~C, ~B, ~RIGHT, ~LEFT, ~DOWN, ~UP};
            3'b111:
                bits_d = {~C, ~B, ~MODE, ~X, ~Y, ~Z};
            3'b000, 3'b001:
                bits_d = {~START, ~A, 2'b00, ~DOWN, ~UP};
            3'b010:
                bits_d = {~START, ~A, 4'b0000};
            3'b011:
                bits_d = {~START, ~A, 4'b1111};
            default:
                bits_d = 6'h3F;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            th_q  <= 1'b1;
            PHASE <= 2'd0;
            timer <= '0;
            DATA  <= 7'h7F;
        end else if (CE) begin
            th_q  <= TH;
            PHASE <= phase_d;
            timer <= timer_d;
            DATA  <= {TH, bits_d};
        end
    end

endmodule

// File: tb/tb_pad6_seq.sv
// Directed bench for pad6_seq: phase sequencing, timeout, 3-button lock, async reset.
module tb_pad6_seq;

    localparam int TIMEOUT = 11520;
    localparam int TW      = 14;

    logic       CLK;
    logic       RESET_N;
    logic       CE;
    logic       J3BUT;
    logic       TH;
    logic       UP, DOWN, LEFT, RIGHT;
    logic       A, B, C, START;
    logic       MODE, X, Y, Z;
    logic [6:0] DATA;
    logic [1:0] PHASE;

    int checks;
    int errors;

    pad6_seq #(
        .TIMEOUT(TIMEOUT),
        .TW     (TW)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .CE     (CE),
        .J3BUT  (J3BUT),
        .TH     (TH),
        .UP     (UP),
        .DOWN   (DOWN),
        .LEFT   (LEFT),
        .RIGHT  (RIGHT),
        .A      (A),
        .B      (B),
        .C      (C),
        .START  (START),
        .MODE   (MODE),
        .X      (X),
        .Y      (Y),
        .Z      (Z),
        .DATA   (DATA),
        .PHASE  (PHASE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic clear_buttons();
        UP = 0; DOWN = 0; LEFT = 0; RIGHT = 0;
        A = 0; B = 0; C = 0; START = 0;
        MODE = 0; X = 0; Y = 0; Z = 0;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        CE      = 1'b0;
        TH      = 1'b1;
        J3BUT   = 1'b0;
        clear_buttons();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    task automatic tick(input logic th);
        TH = th;
        CE = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (DATA !== 7'h7F || PHASE !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: DATA=%h PHASE=%0d want 7f/0", DATA, PHASE);
        end
        RESET_N = 1'b1;
        tick(1'b1);
        checks++;
        if (DATA !== 7'h7F || PHASE !== 2'd0) begin
            errors++;
            $display("FAIL idle_th1: DATA=%h PHASE=%0d want 7f/0", DATA, PHASE);
        end
        tick(1'b0);
        checks++;
        if (DATA !== 7'h33 || PHASE !== 2'd0) begin
            errors++;
            $display("FAIL idle_th0: DATA=%h PHASE=%0d want 33/0", DATA, PHASE);
        end
    endtask

    task automatic test_sequence();
        logic       th_v [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        logic [6:0] d_v  [9] = '{7'h7F, 7'h23, 7'h7F, 7'h23, 7'h7F,
                                 7'h20, 7'h7E, 7'h2F, 7'h7F};
        logic [1:0] p_v  [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        do_reset();
        A = 1;
        Z = 1;
        for (int i = 0; i < 9; i++) begin
            tick(th_v[i]);
            checks++;
            if (DATA !== d_v[i] || PHASE !== p_v[i]) begin
                errors++;
                $display("FAIL seq[%0d]: DATA=%h PHASE=%0d want %h/%0d",
                         i, DATA, PHASE, d_v[i], p_v[i]);
            end
        end
    endtask

    task automatic test_rows_and_ce();
        do_reset();
        LEFT = 1; B = 1; START = 1; DOWN = 1;
        tick(1'b1);
        checks++;
        if (DATA !== 7'h69 || PHASE !== 2'd0) begin
            errors++;
            $display("FAIL row_th1: DATA=%h PHASE=%0d want 69/0", DATA, PHASE);
        end
        tick(1'b0);
        checks++;
        if (DATA !== 7'h11 || PHASE !== 2'd0) begin
            errors++;
            $display("FAIL row_th0: DATA=%h PHASE=%0d want 11/0", DATA, PHASE);
        end
        tick(1'b1);
        checks++;
        if (DATA !== 7'h69 || PHASE !== 2'd1) begin
            errors++;
            $display("FAIL row_p1: DATA=%h PHASE=%0d want 69/1", DATA, PHASE);
        end
        CE = 1'b0;
        TH = 1'b0;
        @(posedge CLK);
        #1;
        TH = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (DATA !== 7'h69 || PHASE !== 2'd1) begin
            errors++;
            $display("FAIL ce_gate: DATA=%h PHASE=%0d want 69/1", DATA, PHASE);
        end
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd1) begin
            errors++;
            $display("FAIL ce_no_rise: PHASE=%0d want 1", PHASE);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd2) begin
            errors++;
            $display("FAIL to_start: PHASE=%0d want 2", PHASE);
        end
        repeat (TIMEOUT - 1) tick(1'b1);
        checks++;
        if (PHASE !== 2'd2) begin
            errors++;
            $display("FAIL to_minus1: PHASE=%0d want 2", PHASE);
        end
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd0 || DATA !== 7'h7F) begin
            errors++;
            $display("FAIL to_expire: DATA=%h PHASE=%0d want 7f/0", DATA, PHASE);
        end
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd0) begin
            errors++;
            $display("FAIL to_hold0: PHASE=%0d want 0", PHASE);
        end
    endtask

    task automatic test_timeout_th_low();
        do_reset();
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        repeat (TIMEOUT - 1) tick(1'b0);
        checks++;
        if (PHASE !== 2'd2 || DATA !== 7'h30) begin
            errors++;
            $display("FAIL tl_id: DATA=%h PHASE=%0d want 30/2", DATA, PHASE);
        end
        tick(1'b0);
        checks++;
        if (PHASE !== 2'd0 || DATA !== 7'h33) begin
            errors++;
            $display("FAIL tl_expire: DATA=%h PHASE=%0d want 33/0", DATA, PHASE);
        end
    endtask

    task automatic test_rise_at_timeout();
        do_reset();
        tick(1'b0);
        tick(1'b1);
        repeat (TIMEOUT - 1) tick(1'b0);
        checks++;
        if (PHASE !== 2'd1) begin
            errors++;
            $display("FAIL rt_pre: PHASE=%0d want 1", PHASE);
        end
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd2 || DATA !== 7'h7F) begin
            errors++;
            $display("FAIL rt_rise: DATA=%h PHASE=%0d want 7f/2", DATA, PHASE);
        end
        repeat (TIMEOUT - 1) tick(1'b1);
        checks++;
        if (PHASE !== 2'd2) begin
            errors++;
            $display("FAIL rt_cleared: PHASE=%0d want 2", PHASE);
        end
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd0) begin
            errors++;
            $display("FAIL rt_expire: PHASE=%0d want 0", PHASE);
        end
    endtask

    task automatic test_j3but();
        do_reset();
        J3BUT = 1;
        UP    = 1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            checks++;
            if (DATA !== 7'h32 || PHASE !== 2'd0) begin
                errors++;
                $display("FAIL j3_th0[%0d]: DATA=%h PHASE=%0d want 32/0",
                         i, DATA, PHASE);
            end
            tick(1'b1);
            checks++;
            if (DATA !== 7'h7E || PHASE !== 2'd0) begin
                errors++;
                $display("FAIL j3_th1[%0d]: DATA=%h PHASE=%0d want 7e/0",
                         i, DATA, PHASE);
            end
        end
        J3BUT = 0;
        UP    = 0;
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd2) begin
            errors++;
            $display("FAIL j3_mid_pre: PHASE=%0d want 2", PHASE);
        end
        J3BUT = 1;
        tick(1'b0);
        checks++;
        if (PHASE !== 2'd0 || DATA !== 7'h33) begin
            errors++;
            $display("FAIL j3_mid: DATA=%h PHASE=%0d want 33/0", DATA, PHASE);
        end
        J3BUT = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            tick(1'b1);
        end
        tick(1'b0);
        checks++;
        if (PHASE !== 2'd3 || DATA !== 7'h3F) begin
            errors++;
            $display("FAIL ar_pre: DATA=%h PHASE=%0d want 3f/3", DATA, PHASE);
        end
        CE = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if (PHASE !== 2'd0 || DATA !== 7'h7F) begin
            errors++;
            $display("FAIL ar_async: DATA=%h PHASE=%0d want 7f/0", DATA, PHASE);
        end
        #1;
        RESET_N = 1'b1;
        tick(1'b0);
        checks++;
        if (PHASE !== 2'd0 || DATA !== 7'h33) begin
            errors++;
            $display("FAIL ar_post0: DATA=%h PHASE=%0d want 33/0", DATA, PHASE);
        end
        tick(1'b1);
        checks++;
        if (PHASE !== 2'd1 || DATA !== 7'h7F) begin
            errors++;
            $display("FAIL ar_post1: DATA=%h PHASE=%0d want 7f/1", DATA, PHASE);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        RESET_N = 1'b0;
        CE      = 1'b0;
        TH      = 1'b1;
        J3BUT   = 1'b0;
        clear_buttons();
        test_reset();
        test_sequence();
        test_rows_and_ce();
        test_timeout();
        test_timeout_th_low();
        test_rise_at_timeout();
        test_j3but();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
